// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM states and opcode helpers.
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_RSUB = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    // Subtractions are formed as x + ~y + 1, so they start with carry 1.
    function automatic logic init_carry(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_RSUB);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bundle of the bit-serial ALU.
// zero/ovf exist only when SERIAL_ALU_FLAGS_EN is defined.
interface serial_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       oper;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             busy;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, oper, a, b, out_ready,
        input  in_ready, out_valid, result, c_out, busy, zero, ovf
    );

    modport slave (
        input  in_valid, oper, a, b, out_ready,
        output in_ready, out_valid, result, c_out, busy, zero, ovf
    );
`else
    modport master (
        output in_valid, oper, a, b, out_ready,
        input  in_ready, out_valid, result, c_out, busy
    );

    modport slave (
        input  in_valid, oper, a, b, out_ready,
        output in_ready, out_valid, result, c_out, busy
    );
`endif
endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; logic opcodes force carry-out to 0.
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic [2:0] oper,
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    output logic       sum,
    output logic       c_out
);
    logic ax;
    logic bx;

    // Per-bit opcode decode; subtractions invert one operand into a full adder.
    always_comb begin
        ax    = a;
        bx    = b;
        sum   = 1'b0;
        c_out = 1'b0;
        case (oper)
            OP_ADD, OP_SUB, OP_RSUB: begin
                if (oper == OP_SUB)  bx = ~b;
                if (oper == OP_RSUB) ax = ~a;
                sum   = ax ^ bx ^ c_in;
                c_out = (ax & bx) | (ax & c_in) | (bx & c_in);
            end
            OP_OR:   sum = a | b;
            OP_AND:  sum = a & b;
            OP_ANDN: sum = ~a & b;
            OP_XOR:  sum = a ^ b;
            OP_XNOR: sum = ~(a ^ b);
            default: sum = 1'b0;
        endcase
    end
endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU controller: accepts an operand pair, walks a 1-bit slice LSB-first for
// WIDTH cycles and returns the assembled word plus final carry.
// Optional zero/ovf flags are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_alu_if.slave bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       oper_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             c_out_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;

    alu_bit_slice u_slice (
        .oper  (oper_q),
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
    always_comb begin
        res_next = {slice_sum, res_q[WIDTH-1:1]};
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q;
    logic ovf_q;

    // Flags are captured on the MSB step, alongside the last result bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == SHIFT && cnt_q == LAST) begin
            zero_q <= (res_next == '0);
            ovf_q  <= is_arith(oper_q) & (carry_q ^ slice_cout);
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

    // Control FSM with registered handshake outputs and the serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            oper_q      <= OP_ADD;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        oper_q     <= bus.oper;
                        carry_q    <= init_carry(bus.oper);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        c_out_q     <= slice_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.c_out     = c_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu at WIDTH=8: directed plan cases plus random operations
// compared against a word-level arithmetic model.
module tb_serial_alu;
    import serial_alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_alu_if #(.WIDTH(8)) bus ();

    serial_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: subtraction as x + ~y + 1, carry is bit 8 of the 9-bit sum.
    function automatic void model(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                                  output logic [7:0] r, output logic c);
        logic [8:0] full;
        full = 9'd0;
        c    = 1'b0;
        case (op)
            OP_ADD:  full = {1'b0, av} + {1'b0, bv};
            OP_SUB:  full = {1'b0, av} + {1'b0, ~bv} + 9'd1;
            OP_RSUB: full = {1'b0, ~av} + {1'b0, bv} + 9'd1;
            OP_OR:   full = {1'b0, av | bv};
            OP_AND:  full = {1'b0, av & bv};
            OP_ANDN: full = {1'b0, ~av & bv};
            OP_XOR:  full = {1'b0, av ^ bv};
            default: full = {1'b0, ~(av ^ bv)};
        endcase
        r = full[7:0];
        if (op == OP_ADD || op == OP_SUB || op == OP_RSUB) c = full[8];
    endfunction

`ifdef SERIAL_ALU_FLAGS_EN
    function automatic logic ovf_model(input logic [2:0] op, input logic [7:0] av,
                                       input logic [7:0] bv);
        int sa;
        int sb;
        int s;
        sa = $signed(av);
        sb = $signed(bv);
        case (op)
            OP_ADD:  s = sa + sb;
            OP_SUB:  s = sa - sb;
            OP_RSUB: s = sb - sa;
            default: s = 0;
        endcase
        return (s > 127) || (s < -128);
    endfunction
`endif

    // One full transaction: issue, time the latency, compare, optionally stall, then drain.
    task automatic do_op(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                         input int stall, input bit scramble);
        logic [7:0] er;
        logic       ec;
        logic [7:0] hr;
        logic       hc;
        int         n;
        model(op, av, bv, er, ec);
        bus.oper     = op;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1'b1);
        check("in_ready_in_shift", bus.in_ready, 1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            if (scramble) begin
                bus.oper = 3'($urandom_range(0, 7));
                bus.a    = 8'($urandom);
                bus.b    = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 32'd8);
        check("result", bus.result, er);
        check("c_out", bus.c_out, ec);
        check("result_is_zero", 32'(bus.result == 8'h00), 32'(er == 8'h00));
`ifdef SERIAL_ALU_FLAGS_EN
        check("zero_flag", bus.zero, 32'(er == 8'h00));
        check("ovf_flag", bus.ovf, ovf_model(op, av, bv));
`endif
        hr = bus.result;
        hc = bus.c_out;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.oper     = 3'($urandom_range(0, 7));
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(posedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1'b1);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_result", bus.result, hr);
            check("stall_c_out", bus.c_out, hc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("drain_out_valid", bus.out_valid, 1'b0);
        check("drain_in_ready", bus.in_ready, 1'b1);
        check("drain_busy", bus.busy, 1'b0);
    endtask

    logic [2:0] dir_op [6] = '{OP_ADD, OP_SUB, OP_SUB, OP_RSUB, OP_XOR, OP_ANDN};
    logic [7:0] dir_a  [6] = '{8'h7F, 8'h05, 8'h07, 8'h03, 8'hF0, 8'hF0};
    logic [7:0] dir_b  [6] = '{8'h01, 8'h07, 8'h07, 8'h0A, 8'h3C, 8'h3C};

    initial begin
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.oper      = OP_ADD;
        bus.a         = 8'h00;
        bus.b         = 8'h00;

        // Reset values while held in reset.
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_result", bus.result, 8'h00);
        check("rst_c_out", bus.c_out, 1'b0);
`ifdef SERIAL_ALU_FLAGS_EN
        check("rst_zero", bus.zero, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", bus.in_ready, 1'b1);

        // Directed plan cases; the SUB a==b case carries the backpressure stall.
        for (int i = 0; i < 6; i++) begin
            do_op(dir_op[i], dir_a[i], dir_b[i], (i == 2) ? 5 : 0, 1'b0);
        end

        // Operand scrambling during SHIFT must not disturb the latched operation.
        do_op(OP_SUB, 8'h5A, 8'hC3, 0, 1'b1);
        do_op(OP_XNOR, 8'h96, 8'h0F, 1, 1'b1);

        // Random operations with random stall and scrambling.
        for (int i = 0; i < 30; i++) begin
            do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Reset pulsed mid-operation at bit 3.
        bus.oper     = OP_ADD;
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
        bus.in_valid = 1'b1;
        check("midrst_pre_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_result", bus.result, 8'h00);
        check("midrst_c_out", bus.c_out, 1'b0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_ready", bus.in_ready, 1'b1);
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check("midrst_no_out_valid", seen_valid, 1'b0);
        do_op(OP_ADD, 8'h01, 8'h01, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
